// File: rtl/timer_sched.sv
// timer_sched
// Shared one-shot timer. Requesters are arbitrated round-robin. The winner's
// programmed length is loaded, counted down on enabled ticks, and a single
// cycle done pulse is returned to the winner. One IDLE cycle always separates
// two owners.
//
// Ports:
//   i_clk        clock, all state updates on rising edge
//   i_rst        asynchronous active-high reset
//   i_req        level request per requester
//   i_len        per-requester timeout length, slice [n*WIDTH +: WIDTH]
//   i_tick       count enable (prescaler strobe)
//   i_cancel     abort the timing in progress
//   o_grant      one-hot owner of the timer
//   o_done       one-cycle expiry pulse to the owner
//   o_busy       high whenever the scheduler is not idle
//   o_remaining  current count value
module timer_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_len,
  input  logic                  i_tick,
  input  logic                  i_cancel,
  output logic [NREQ-1:0]       o_grant,
  output logic [NREQ-1:0]       o_done,
  output logic                  o_busy,
  output logic [WIDTH-1:0]      o_remaining
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     owner_q, owner_d;

  // Per-requester length slices as an array for indexed selection.
  logic [WIDTH-1:0]  len_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
      assign len_arr[gi] = i_len[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search: first set request starting at rr_q, wrapping.
  logic          win_found;
  logic [IW-1:0] win_idx;
  int            pos;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(rr_q) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!win_found && i_req[pos]) begin
        win_found = 1'b1;
        win_idx   = pos[IW-1:0];
      end
    end
  end

  // Pointer moves past the departing owner, whether it expired or was cancelled.
  logic [IW-1:0] rr_next;
  assign rr_next = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_RUN;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
          count_d = len_arr[win_idx];
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        // Cancel beats both expiry and tick on the same edge.
        if (i_cancel) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = rr_next;
        end else if (count_q == '0) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end else if (i_tick) begin
          count_d = count_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        rr_d    = rr_next;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_done      = done_q;
  assign o_busy      = busy_q;
  assign o_remaining = count_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed testbench for timer_sched (NREQ=4, WIDTH=16).
module tb_timer_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic                  i_clk;
  logic                  i_rst;
  logic [NREQ-1:0]       i_req;
  logic [NREQ*WIDTH-1:0] i_len;
  logic                  i_tick;
  logic                  i_cancel;
  logic [NREQ-1:0]       o_grant;
  logic [NREQ-1:0]       o_done;
  logic                  o_busy;
  logic [WIDTH-1:0]      o_remaining;

  int n_checks = 0;
  int n_errors = 0;

  timer_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_len       (i_len),
    .i_tick      (i_tick),
    .i_cancel    (i_cancel),
    .o_grant     (o_grant),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .o_remaining (o_remaining)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_len(input int n, input logic [WIDTH-1:0] v);
    i_len[n*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic b, input logic [15:0] r);
    check({tag, ".grant"}, 32'(o_grant), 32'(g));
    check({tag, ".done"},  32'(o_done),  32'(d));
    check({tag, ".busy"},  32'(o_busy),  32'(b));
    check({tag, ".rem"},   32'(o_remaining), 32'(r));
  endtask

  initial begin
    i_rst = 1'b1; i_req = '0; i_len = '0; i_tick = 1'b0; i_cancel = 1'b0;
    #12;
    check_all("reset", 4'b0000, 4'b0000, 1'b0, 16'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    step();

    // Single request on req1, L=5, tick held high; rr=0 -> rr=2 afterwards.
    i_tick = 1'b1;
    set_len(1, 16'd5);
    set_len(0, 16'd77);  // loser length, must not matter
    i_req = 4'b0010;
    step();
    check_all("r1.grant", 4'b0010, 4'b0000, 1'b1, 16'd5);
    i_req = 4'b0000;
    set_len(1, 16'd99);  // late change must be ignored
    for (int i = 4; i >= 0; i--) begin
      step();
      check("r1.rem", 32'(o_remaining), 32'(i));
      check("r1.nodone", 32'(o_done), 32'd0);
    end
    step();
    check_all("r1.done", 4'b0010, 4'b0010, 1'b1, 16'd0);
    step();
    check_all("r1.idle", 4'b0000, 4'b0000, 1'b0, 16'd0);

    // L=0 on req2: done on the cycle after the grant.
    set_len(2, 16'd0);
    i_req = 4'b0100;
    step();
    check_all("l0.grant", 4'b0100, 4'b0000, 1'b1, 16'd0);
    i_req = 4'b0000;
    step();
    check_all("l0.done", 4'b0100, 4'b0100, 1'b1, 16'd0);
    step();
    check_all("l0.idle", 4'b0000, 4'b0000, 1'b0, 16'd0);

    // Tick every other cycle, L=3 on req3 (rr=3).
    i_tick = 1'b0;
    set_len(3, 16'd3);
    i_req = 4'b1000;
    step();
    check_all("tg.grant", 4'b1000, 4'b0000, 1'b1, 16'd3);
    i_req = 4'b0000;
    begin
      logic [15:0] exp_rem [6] = '{16'd3, 16'd2, 16'd2, 16'd1, 16'd1, 16'd0};
      for (int i = 0; i < 6; i++) begin
        i_tick = (i % 2 == 1);
        step();
        check("tg.rem", 32'(o_remaining), 32'(exp_rem[i]));
        check("tg.nodone", 32'(o_done), 32'd0);
      end
    end
    i_tick = 1'b0;
    step();
    check_all("tg.done", 4'b1000, 4'b1000, 1'b1, 16'd0);
    step();
    check_all("tg.idle", 4'b0000, 4'b0000, 1'b0, 16'd0);

    // All four requesting, L=2 each; rr=0 so order 0,1,2,3,0.
    i_tick = 1'b1;
    for (int n = 0; n < NREQ; n++) set_len(n, 16'd2);
    i_req = 4'b1111;
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        step();
        check("rr.grant", 32'(o_grant), 32'(1) << order[k]);
        step();
        step();
        check("rr.rem0", 32'(o_remaining), 32'd0);
        step();
        check("rr.done", 32'(o_done), 32'(1) << order[k]);
        step();
        check("rr.gap.grant", 32'(o_grant), 32'd0);
        check("rr.gap.done", 32'(o_done), 32'd0);
        check("rr.gap.busy", 32'(o_busy), 32'd0);
      end
    end
    i_req = 4'b0000;

    // Cancel at count 4 of L=8 on req0 with req1 pending (rr=1, only req0 asks first).
    set_len(0, 16'd8);
    set_len(1, 16'd1);
    i_req = 4'b0001;
    step();
    check_all("cn.grant", 4'b0001, 4'b0000, 1'b1, 16'd8);
    i_req = 4'b0011;
    for (int i = 0; i < 4; i++) step();
    check("cn.rem4", 32'(o_remaining), 32'd4);
    i_cancel = 1'b1;
    step();
    i_cancel = 1'b0;
    check("cn.grant0", 32'(o_grant), 32'd0);
    check("cn.nodone", 32'(o_done), 32'd0);
    check("cn.busy0", 32'(o_busy), 32'd0);
    step();
    check_all("cn.next", 4'b0010, 4'b0000, 1'b1, 16'd1);
    i_req = 4'b0000;
    step();
    check("cz.rem0", 32'(o_remaining), 32'd0);
    // Cancel on the same edge that would expire.
    i_cancel = 1'b1;
    step();
    i_cancel = 1'b0;
    check("cz.grant0", 32'(o_grant), 32'd0);
    check("cz.nodone", 32'(o_done), 32'd0);
    step();
    check("cz.nodone2", 32'(o_done), 32'd0);
    check("cz.busy0", 32'(o_busy), 32'd0);

    // Reset mid-RUN: req0 L=10, reset after 4 ticks (rr=2 now).
    set_len(0, 16'd10);
    i_req = 4'b0001;
    step();
    check_all("rs.grant", 4'b0001, 4'b0000, 1'b1, 16'd10);
    i_req = 4'b0000;
    for (int i = 0; i < 4; i++) step();
    check("rs.rem6", 32'(o_remaining), 32'd6);
    i_rst = 1'b1;
    #1;
    check_all("rs.async", 4'b0000, 4'b0000, 1'b0, 16'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_req = 4'b1111;
    step();
    check("rs.rr0", 32'(o_grant), 32'd1);
    check("rs.len", 32'(o_remaining), 32'd10);
    i_req = 4'b0000;
    i_cancel = 1'b1;
    step();
    i_cancel = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
